ysyx_bus_arb: RTL and testbench

Arbitrates the L1 instruction-cache bus (`l1i_bus_if`) and the L1 data-cache bus (`l1d_bus_if`) onto one AXI4 memory master port. It sits directly downstream of both L1 caches, as the slave of each interface, and upstream of the SoC crossbar. It serialises one transaction at a time with fixed priority: D-write, then D-read, then I-read. Instruction refills are issued as INCR bursts; data accesses are single-beat.

---
 rtl/ysyx_bus_arb_pkg.sv | 37 +++
 rtl/ysyx_bus_arb_if.sv | 45 ++++
 rtl/ysyx_bus_arb_wch.sv | 47 ++++
 rtl/ysyx_bus_arb.sv | 189 ++++++++++++++++++
 tb/tb_ysyx_bus_arb.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_bus_arb_pkg.sv
// Shared types and helpers for the L1-to-AXI bus arbiter.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

package ysyx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    I_AR,
    I_R,
    D_AR,
    D_R,
    D_W,
    D_B
  } bus_arb_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Byte-strobe pattern to AXI size; unrecognised patterns fall back to a word.
  function automatic logic [2:0] strb2size(input logic [7:0] strb);
    case (strb)
      8'h01:   return 3'd0;
      8'h03:   return 3'd1;
      8'h0F:   return 3'd2;
      8'hFF:   return 3'd3;
      default: return 3'd2;
    endcase
  endfunction

  // Contiguous low-order mask with cnt ones, so a popcount can reuse strb2size.
  function automatic logic [7:0] cnt2mask(input logic [3:0] cnt);
    return 8'((9'd1 << cnt) - 9'd1);
  endfunction

endpackage

// File: rtl/ysyx_bus_arb_if.sv
// L1 instruction- and data-cache bus interfaces seen by the arbiter.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

interface l1i_bus_if #(
  parameter int unsigned XLEN = `YSYX_XLEN
) ();
  logic            arvalid;
  logic [XLEN-1:0] araddr;
  logic            rready;
  logic [XLEN-1:0] rdata;
  logic            rvalid;
  logic            rlast;

  modport master (output arvalid, araddr, input rready, rdata, rvalid, rlast);
  modport slave  (input arvalid, araddr, output rready, rdata, rvalid, rlast);
endinterface

interface l1d_bus_if #(
  parameter int unsigned XLEN = `YSYX_XLEN
) ();
  logic              arvalid;
  logic [XLEN-1:0]   araddr;
  logic [7:0]        rstrb;
  logic              awvalid;
  logic [XLEN-1:0]   awaddr;
  logic              wvalid;
  logic [XLEN-1:0]   wdata;
  logic [XLEN/8-1:0] wstrb;
  logic              rready;
  logic [XLEN-1:0]   rdata;
  logic              rvalid;
  logic              rlast;
  logic              wready;

  modport master (
    output arvalid, araddr, rstrb, awvalid, awaddr, wvalid, wdata, wstrb,
    input  rready, rdata, rvalid, rlast, wready
  );
  modport slave (
    input  arvalid, araddr, rstrb, awvalid, awaddr, wvalid, wdata, wstrb,
    output rready, rdata, rvalid, rlast, wready
  );
endinterface

// File: rtl/ysyx_bus_arb_wch.sv
// AW/W dual-handshake tracker: raises both valids together, drops each on its own ack.
module ysyx_bus_arb_wch (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic m_awready,
  input  logic m_wready,
  output logic m_awvalid,
  output logic m_wvalid,
  output logic done_c
);

  logic aw_done;
  logic w_done;
  logic aw_hs_c;
  logic w_hs_c;

  assign aw_hs_c = m_awvalid && m_awready;
  assign w_hs_c  = m_wvalid && m_wready;

  // Done in the cycle the later of the two handshakes completes.
  assign done_c = (aw_done || aw_hs_c) && (w_done || w_hs_c);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else if (start) begin
      m_awvalid <= 1'b1;
      m_wvalid  <= 1'b1;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      if (aw_hs_c) begin
        m_awvalid <= 1'b0;
        aw_done   <= 1'b1;
      end
      if (w_hs_c) begin
        m_wvalid <= 1'b0;
        w_done   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_bus_arb.sv
// Serialises L1I refills and L1D accesses onto one AXI4 master port.
// Fixed priority D-write > D-read > I-read, re-evaluated only in IDLE.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_bus_arb
  import ysyx_pkg::*;
#(
  parameter int unsigned XLEN      = `YSYX_XLEN,
  parameter int unsigned L1I_BEATS = 4
) (
  input  logic              clock,
  input  logic              reset,
  l1i_bus_if.slave          l1i,
  l1d_bus_if.slave          l1d,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [XLEN-1:0]   m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [XLEN-1:0]   m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [XLEN-1:0]   m_awaddr,
  output logic [2:0]        m_awsize,
  output logic              m_wvalid,
  input  logic              m_wready,
  output logic [XLEN-1:0]   m_wdata,
  output logic [XLEN/8-1:0] m_wstrb,
  output logic              m_wlast,
  input  logic              m_bvalid,
  output logic              m_bready,
  input  logic [1:0]        m_bresp,
  output logic              bus_err
);

  localparam int unsigned STRB_W = XLEN / 8;
  localparam logic [2:0]  I_SIZE = 3'($clog2(STRB_W));
  localparam logic [7:0]  I_LEN  = 8'(L1I_BEATS - 1);

  bus_arb_state_e state;
  logic           i_flush;
  logic           i_rready;
  logic           d_rready;
  logic           d_wready;
  logic [3:0]     wstrb_cnt_c;
  logic           pick_dw_c;
  logic           wch_start_c;
  logic           wch_done_c;
  logic           i_rvalid_c;
  logic           d_rvalid_c;

  // A write request is still held in the cycle its wready pulse is visible; don't re-accept it.
  assign pick_dw_c   = l1d.awvalid && l1d.wvalid && !d_wready;
  assign wch_start_c = (state == IDLE) && pick_dw_c;
  assign wstrb_cnt_c = 4'($countones(l1d.wstrb));

  assign m_arburst = AXI_BURST_INCR;
  assign m_wlast   = 1'b1;

  ysyx_bus_arb_wch u_wch (
    .clock     (clock),
    .reset     (reset),
    .start     (wch_start_c),
    .m_awready (m_awready),
    .m_wready  (m_wready),
    .m_awvalid (m_awvalid),
    .m_wvalid  (m_wvalid),
    .done_c    (wch_done_c)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      m_rready  <= 1'b0;
      m_bready  <= 1'b0;
      m_awaddr  <= '0;
      m_awsize  <= '0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      i_flush   <= 1'b0;
      i_rready  <= 1'b0;
      d_rready  <= 1'b0;
      d_wready  <= 1'b0;
    end else begin
      i_rready <= 1'b0;
      d_rready <= 1'b0;
      d_wready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_dw_c) begin
            state    <= D_W;
            m_awaddr <= l1d.awaddr;
            m_awsize <= strb2size(cnt2mask(wstrb_cnt_c));
            m_wdata  <= l1d.wdata;
            m_wstrb  <= l1d.wstrb;
          end else if (l1d.arvalid) begin
            state     <= D_AR;
            m_arvalid <= 1'b1;
            m_araddr  <= l1d.araddr;
            m_arlen   <= 8'd0;
            m_arsize  <= strb2size(l1d.rstrb);
          end else if (l1i.arvalid) begin
            state     <= I_AR;
            m_arvalid <= 1'b1;
            m_araddr  <= l1i.araddr;
            m_arlen   <= I_LEN;
            m_arsize  <= I_SIZE;
            i_flush   <= 1'b0;
          end
        end
        // Once the I-side withdraws, the rest of the burst is drained silently.
        I_AR: begin
          if (!l1i.arvalid) i_flush <= 1'b1;
          if (m_arready) begin
            state     <= I_R;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            i_rready  <= 1'b1;
          end
        end
        I_R: begin
          if (!l1i.arvalid) i_flush <= 1'b1;
          if (m_rvalid && m_rlast) begin
            state    <= IDLE;
            m_rready <= 1'b0;
          end
        end
        D_AR: begin
          if (m_arready) begin
            state     <= D_R;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            d_rready  <= 1'b1;
          end
        end
        D_R: begin
          if (m_rvalid) begin
            state    <= IDLE;
            m_rready <= 1'b0;
          end
        end
        D_W: begin
          if (wch_done_c) begin
            state    <= D_B;
            m_bready <= 1'b1;
          end
        end
        D_B: begin
          if (m_bvalid) begin
            state    <= IDLE;
            m_bready <= 1'b0;
            d_wready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data is a zero-latency pass-through, gated by the owning R state.
  assign i_rvalid_c = (state == I_R) && m_rvalid && !i_flush && l1i.arvalid;
  assign d_rvalid_c = (state == D_R) && m_rvalid;

  assign l1i.rready = i_rready;
  assign l1i.rvalid = i_rvalid_c;
  assign l1i.rlast  = i_rvalid_c && m_rlast;
  assign l1i.rdata  = (state == I_R) ? m_rdata : '0;

  assign l1d.rready = d_rready;
  assign l1d.wready = d_wready;
  assign l1d.rvalid = d_rvalid_c;
  assign l1d.rlast  = d_rvalid_c;
  assign l1d.rdata  = (state == D_R) ? m_rdata : '0;

  assign bus_err = (m_rvalid && m_rready && (m_rresp != AXI_RESP_OKAY)) ||
                   (m_bvalid && m_bready && (m_bresp != AXI_RESP_OKAY));

endmodule

// File: tb/tb_ysyx_bus_arb.sv
// Directed bench for ysyx_bus_arb: vector tables for D-reads/writes plus refill, contention, flush and reset sequences.
module tb_ysyx_bus_arb;
  import ysyx_pkg::*;

  localparam int unsigned XLEN = 32;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  rstrb;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int unsigned ar_dly;
    logic [2:0]  exp_size;
    logic        exp_err;
  } rd_vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;
    int unsigned aw_dly;
    int unsigned w_dly;
    logic [2:0]  exp_size;
    logic        exp_err;
  } wr_vec_t;

  logic        clock;
  logic        reset;
  logic        m_arvalid, m_arready;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_rvalid, m_rready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic        m_awvalid, m_awready;
  logic [31:0] m_awaddr;
  logic [2:0]  m_awsize;
  logic        m_wvalid, m_wready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast;
  logic        m_bvalid, m_bready;
  logic [1:0]  m_bresp;
  logic        bus_err;

  int checks;
  int errors;

  l1i_bus_if #(.XLEN(XLEN)) l1i ();
  l1d_bus_if #(.XLEN(XLEN)) l1d ();

  ysyx_bus_arb #(.XLEN(XLEN), .L1I_BEATS(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .l1i       (l1i),
    .l1d       (l1d),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_araddr  (m_araddr),
    .m_arlen   (m_arlen),
    .m_arsize  (m_arsize),
    .m_arburst (m_arburst),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rlast   (m_rlast),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_awaddr  (m_awaddr),
    .m_awsize  (m_awsize),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_wlast   (m_wlast),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready),
    .m_bresp   (m_bresp),
    .bus_err   (bus_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic d_read(input rd_vec_t v);
    l1d.arvalid = 1'b1;
    l1d.araddr  = v.addr;
    l1d.rstrb   = v.rstrb;
    settle();
    chk("rd_req_arvalid_low", 64'(m_arvalid), 64'd0);
    cyc();
    for (int k = 0; k <= int'(v.ar_dly); k++) begin
      m_arready = (k == int'(v.ar_dly));
      settle();
      chk("rd_arvalid", 64'(m_arvalid), 64'd1);
      chk("rd_araddr", 64'(m_araddr), 64'(v.addr));
      chk("rd_arsize", 64'(m_arsize), 64'(v.exp_size));
      chk("rd_arlen", 64'(m_arlen), 64'd0);
      chk("rd_arburst", 64'(m_arburst), 64'd1);
      cyc();
    end
    m_arready = 1'b0;
    m_rvalid  = 1'b1;
    m_rdata   = v.rdata;
    m_rresp   = v.rresp;
    settle();
    chk("rd_rvalid", 64'(l1d.rvalid), 64'd1);
    chk("rd_rdata", 64'(l1d.rdata), 64'(v.rdata));
    chk("rd_rlast", 64'(l1d.rlast), 64'd1);
    chk("rd_rready_pulse", 64'(l1d.rready), 64'd1);
    chk("rd_m_rready", 64'(m_rready), 64'd1);
    chk("rd_bus_err", 64'(bus_err), 64'(v.exp_err));
    chk("rd_arvalid_dropped", 64'(m_arvalid), 64'd0);
    cyc();
    l1d.arvalid = 1'b0;
    m_rvalid    = 1'b0;
    m_rresp     = 2'b00;
    settle();
    chk("rd_idle_m_rready", 64'(m_rready), 64'd0);
    chk("rd_idle_rready", 64'(l1d.rready), 64'd0);
    chk("rd_idle_bus_err", 64'(bus_err), 64'd0);
    cyc();
  endtask

  task automatic d_write(input wr_vec_t v);
    int unsigned last;
    last = (v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly;
    l1d.awvalid = 1'b1;
    l1d.wvalid  = 1'b1;
    l1d.awaddr  = v.addr;
    l1d.wdata   = v.data;
    l1d.wstrb   = v.wstrb;
    settle();
    chk("wr_req_awvalid_low", 64'(m_awvalid), 64'd0);
    cyc();
    for (int k = 0; k <= int'(last); k++) begin
      m_awready = (k == int'(v.aw_dly));
      m_wready  = (k == int'(v.w_dly));
      settle();
      chk("wr_awvalid", 64'(m_awvalid), 64'(k <= int'(v.aw_dly)));
      chk("wr_wvalid", 64'(m_wvalid), 64'(k <= int'(v.w_dly)));
      chk("wr_awaddr", 64'(m_awaddr), 64'(v.addr));
      chk("wr_awsize", 64'(m_awsize), 64'(v.exp_size));
      chk("wr_wdata", 64'(m_wdata), 64'(v.data));
      chk("wr_wstrb", 64'(m_wstrb), 64'(v.wstrb));
      chk("wr_wlast", 64'(m_wlast), 64'd1);
      chk("wr_bready_early", 64'(m_bready), 64'd0);
      cyc();
    end
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b1;
    m_bresp   = v.bresp;
    settle();
    chk("wr_bready", 64'(m_bready), 64'd1);
    chk("wr_bus_err", 64'(bus_err), 64'(v.exp_err));
    chk("wr_wready_early", 64'(l1d.wready), 64'd0);
    cyc();
    m_bvalid = 1'b0;
    m_bresp  = 2'b00;
    settle();
    chk("wr_wready_pulse", 64'(l1d.wready), 64'd1);
    chk("wr_bready_drop", 64'(m_bready), 64'd0);
    chk("wr_err_clear", 64'(bus_err), 64'd0);
    cyc();
    l1d.awvalid = 1'b0;
    l1d.wvalid  = 1'b0;
    settle();
    chk("wr_wready_single", 64'(l1d.wready), 64'd0);
    chk("wr_no_reissue", 64'(m_awvalid), 64'd0);
    cyc();
  endtask

  // keep = number of leading beats the I-side still wants before withdrawing.
  task automatic run_irefill(input logic [31:0] addr, input int keep);
    l1i.arvalid = 1'b1;
    l1i.araddr  = addr;
    settle();
    chk("i_req_arvalid_low", 64'(m_arvalid), 64'd0);
    cyc();
    m_arready = 1'b1;
    settle();
    chk("i_arvalid", 64'(m_arvalid), 64'd1);
    chk("i_araddr", 64'(m_araddr), 64'(addr));
    chk("i_arlen", 64'(m_arlen), 64'd3);
    chk("i_arsize", 64'(m_arsize), 64'd2);
    chk("i_arburst", 64'(m_arburst), 64'd1);
    cyc();
    for (int b = 0; b < 4; b++) begin
      m_arready = 1'b0;
      if (b >= keep) l1i.arvalid = 1'b0;
      m_rvalid = 1'b1;
      m_rdata  = 32'hA5A5_0000 + 32'(b);
      m_rlast  = (b == 3);
      settle();
      chk("i_m_rready", 64'(m_rready), 64'd1);
      chk("i_rvalid", 64'(l1i.rvalid), 64'(b < keep));
      chk("i_rlast", 64'(l1i.rlast), 64'((b == 3) && (b < keep)));
      chk("i_rready_pulse", 64'(l1i.rready), 64'(b == 0));
      if (b < keep) chk("i_rdata", 64'(l1i.rdata), 64'(32'hA5A5_0000 + 32'(b)));
      cyc();
    end
    l1i.arvalid = 1'b0;
    m_rvalid    = 1'b0;
    m_rlast     = 1'b0;
    settle();
    chk("i_done_m_rready", 64'(m_rready), 64'd0);
    chk("i_done_arvalid", 64'(m_arvalid), 64'd0);
    chk("i_done_rvalid", 64'(l1i.rvalid), 64'd0);
    cyc();
  endtask

  initial begin
    rd_vec_t rv[8];
    wr_vec_t wv[6];

    rv[0] = '{32'h1000_0000, 8'h01, 32'hDEAD_0001, 2'b00, 0, 3'd0, 1'b0};
    rv[1] = '{32'h1000_0006, 8'h03, 32'h1234_5678, 2'b00, 1, 3'd1, 1'b0};
    rv[2] = '{32'h1000_0008, 8'h0F, 32'hCAFE_F00D, 2'b00, 0, 3'd2, 1'b0};
    rv[3] = '{32'h1000_0010, 8'hFF, 32'h0BAD_BEEF, 2'b00, 2, 3'd3, 1'b0};
    rv[4] = '{32'h1000_0014, 8'h07, 32'h5555_AAAA, 2'b00, 0, 3'd2, 1'b0};
    rv[5] = '{32'h1000_0018, 8'h00, 32'h0F0F_0F0F, 2'b00, 0, 3'd2, 1'b0};
    rv[6] = '{32'h1000_001C, 8'h0F, 32'h8765_4321, 2'b10, 0, 3'd2, 1'b1};
    rv[7] = '{32'h1000_0020, 8'h01, 32'h1111_2222, 2'b11, 1, 3'd0, 1'b1};

    wv[0] = '{32'h0F00_0010, 32'h1357_9BDF, 4'b1111, 2'b00, 3, 0, 3'd2, 1'b0};
    wv[1] = '{32'h0F00_0020, 32'h0000_00AA, 4'b0001, 2'b00, 0, 0, 3'd0, 1'b0};
    wv[2] = '{32'h0F00_0024, 32'hAA00_AA00, 4'b1010, 2'b00, 0, 2, 3'd1, 1'b0};
    wv[3] = '{32'h0F00_0028, 32'h00CC_CCCC, 4'b0111, 2'b00, 1, 1, 3'd2, 1'b0};
    wv[4] = '{32'h0F00_002C, 32'hFFFF_FFFF, 4'b1111, 2'b10, 1, 0, 3'd2, 1'b1};
    wv[5] = '{32'h0F00_0030, 32'h0000_0000, 4'b0000, 2'b00, 0, 0, 3'd2, 1'b0};

    checks = 0;
    errors = 0;
    reset  = 1'b0;
    l1i.arvalid = 1'b0; l1i.araddr = '0;
    l1d.arvalid = 1'b0; l1d.araddr = '0; l1d.rstrb = '0;
    l1d.awvalid = 1'b0; l1d.awaddr = '0; l1d.wvalid = 1'b0;
    l1d.wdata = '0; l1d.wstrb = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = '0;

    cyc();
    settle();
    chk("rst_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_awvalid", 64'(m_awvalid), 64'd0);
    chk("rst_wvalid", 64'(m_wvalid), 64'd0);
    chk("rst_rready", 64'(m_rready), 64'd0);
    chk("rst_bready", 64'(m_bready), 64'd0);
    chk("rst_arlen", 64'(m_arlen), 64'd0);
    chk("rst_arburst", 64'(m_arburst), 64'd1);
    chk("rst_wlast", 64'(m_wlast), 64'd1);
    chk("rst_l1d_wready", 64'(l1d.wready), 64'd0);
    cyc();
    reset = 1'b1;

    run_irefill(32'h8000_0000, 4);

    // Contention: both sides request together, D-read wins.
    l1i.arvalid = 1'b1;
    l1i.araddr  = 32'h8000_0100;
    l1d.arvalid = 1'b1;
    l1d.araddr  = 32'h2000_0000;
    l1d.rstrb   = 8'h03;
    settle();
    chk("con_arvalid_low", 64'(m_arvalid), 64'd0);
    cyc();
    m_arready = 1'b1;
    settle();
    chk("con_d_first_addr", 64'(m_araddr), 64'h2000_0000);
    chk("con_d_arsize", 64'(m_arsize), 64'd1);
    chk("con_d_arlen", 64'(m_arlen), 64'd0);
    cyc();
    m_arready = 1'b0;
    m_rvalid  = 1'b1;
    m_rlast   = 1'b1;
    m_rdata   = 32'h0000_BEEF;
    settle();
    chk("con_d_rvalid", 64'(l1d.rvalid), 64'd1);
    chk("con_d_rlast", 64'(l1d.rlast), 64'd1);
    chk("con_d_rdata", 64'(l1d.rdata), 64'h0000_BEEF);
    chk("con_i_rvalid", 64'(l1i.rvalid), 64'd0);
    cyc();
    l1d.arvalid = 1'b0;
    m_rvalid    = 1'b0;
    m_rlast     = 1'b0;
    run_irefill(32'h8000_0100, 4);

    for (int i = 0; i < 8; i++) d_read(rv[i]);
    for (int i = 0; i < 6; i++) d_write(wv[i]);

    run_irefill(32'h8000_0200, 1);

    // Reset in the middle of I_R beat 2.
    l1i.arvalid = 1'b1;
    l1i.araddr  = 32'h8000_0040;
    cyc();
    m_arready = 1'b1;
    cyc();
    m_arready = 1'b0;
    m_rvalid  = 1'b1;
    m_rdata   = 32'h0000_0001;
    cyc();
    m_rdata = 32'h0000_0002;
    settle();
    chk("mid_rvalid_before_rst", 64'(l1i.rvalid), 64'd1);
    reset = 1'b0;
    settle();
    chk("mid_rst_m_rready", 64'(m_rready), 64'd0);
    chk("mid_rst_rvalid", 64'(l1i.rvalid), 64'd0);
    chk("mid_rst_rdata", 64'(l1i.rdata), 64'd0);
    chk("mid_rst_araddr", 64'(m_araddr), 64'd0);
    chk("mid_rst_arlen", 64'(m_arlen), 64'd0);
    chk("mid_rst_arsize", 64'(m_arsize), 64'd0);
    l1i.arvalid = 1'b0;
    m_rvalid    = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    d_read(rv[2]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
